// File: rtl/eros_pwr_seq.sv
// Power sequencer: gates the hart clock after a configurable idle window, then runs a
// bank power-off or retention handshake; wake reverses the sequence. Outputs are registered Moore decodes of the state.
module eros_pwr_seq #(
  parameter int NHARTS  = 3,
  parameter int N_BANKS = 2,
  parameter int CNT_W   = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NHARTS-1:0]  sleep_i,
  input  logic               wake_i,
  input  logic               cfg_en_i,
  input  logic [CNT_W-1:0]   cfg_idle_cycles_i,
  input  logic               cfg_retentive_i,
  output logic               clk_en_o,
  output logic [N_BANKS-1:0] pwrgate_no,
  input  logic [N_BANKS-1:0] pwrgate_ack_ni,
  output logic [N_BANKS-1:0] set_retentive_no,
  output logic [2:0]         state_o,
  output logic               asleep_o
);

  typedef enum logic [2:0] {
    ST_ACTIVE   = 3'd0,
    ST_IDLE     = 3'd1,
    ST_GATE_CLK = 3'd2,
    ST_PD_WAIT  = 3'd3,
    ST_SLEEP    = 3'd4,
    ST_PU_WAIT  = 3'd5,
    ST_UNGATE   = 3'd6
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               mode_q, mode_d;
  logic               wake_pend_q, wake_pend_d;
  logic               clk_en_q, clk_en_d;
  logic [N_BANKS-1:0] pwrgate_n_q, pwrgate_n_d;
  logic [N_BANKS-1:0] set_ret_n_q, set_ret_n_d;
  logic               asleep_q, asleep_d;

  logic all_asleep;
  assign all_asleep = &sleep_i;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mode_d      = mode_q;
    wake_pend_d = wake_pend_q;
    case (state_q)
      ST_ACTIVE: begin
        if (cfg_en_i && all_asleep && !wake_i) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        // Any reason to stay awake beats idle-window expiry.
        if (wake_i || !cfg_en_i || !all_asleep) begin
          state_d = ST_ACTIVE;
        end else if (cnt_q == cfg_idle_cycles_i) begin
          state_d = ST_GATE_CLK;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GATE_CLK: begin
        mode_d      = cfg_retentive_i;
        wake_pend_d = wake_pend_q | wake_i;
        state_d     = cfg_retentive_i ? ST_SLEEP : ST_PD_WAIT;
      end
      ST_PD_WAIT: begin
        // A wake here is remembered; the power-off handshake always completes first.
        wake_pend_d = wake_pend_q | wake_i;
        if (pwrgate_ack_ni == '0) begin
          state_d = ST_SLEEP;
        end
      end
      ST_SLEEP: begin
        if (wake_i || wake_pend_q) begin
          wake_pend_d = 1'b0;
          state_d     = mode_q ? ST_UNGATE : ST_PU_WAIT;
        end
      end
      ST_PU_WAIT: begin
        if (&pwrgate_ack_ni) begin
          state_d = ST_UNGATE;
        end
      end
      ST_UNGATE: state_d = ST_ACTIVE;
      default:   state_d = ST_ACTIVE;
    endcase
  end

  // Output flops decode the next state so they line up with state_q.
  always_comb begin
    clk_en_d    = (state_d == ST_ACTIVE) || (state_d == ST_IDLE);
    pwrgate_n_d = '1;
    set_ret_n_d = '1;
    if (((state_d == ST_PD_WAIT) || (state_d == ST_SLEEP)) && !mode_d) begin
      pwrgate_n_d = '0;
    end
    if ((state_d == ST_SLEEP) && mode_d) begin
      set_ret_n_d = '0;
    end
    asleep_d = (state_d == ST_SLEEP);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= ST_ACTIVE;
      cnt_q       <= '0;
      mode_q      <= 1'b0;
      wake_pend_q <= 1'b0;
      clk_en_q    <= 1'b1;
      pwrgate_n_q <= '1;
      set_ret_n_q <= '1;
      asleep_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mode_q      <= mode_d;
      wake_pend_q <= wake_pend_d;
      clk_en_q    <= clk_en_d;
      pwrgate_n_q <= pwrgate_n_d;
      set_ret_n_q <= set_ret_n_d;
      asleep_q    <= asleep_d;
    end
  end

  assign clk_en_o         = clk_en_q;
  assign pwrgate_no       = pwrgate_n_q;
  assign set_retentive_no = set_ret_n_q;
  assign state_o          = state_q;
  assign asleep_o         = asleep_q;

endmodule

// File: tb/tb_eros_pwr_seq.sv
// Directed bench for eros_pwr_seq: a vector table for the main power-down/up flows,
// then hand-written sequences for idle abort, deferred wake and mid-handshake reset.
module tb_eros_pwr_seq;

  localparam logic [2:0] S_ACT = 3'd0, S_IDL = 3'd1, S_GAT = 3'd2, S_PDW = 3'd3,
                         S_SLP = 3'd4, S_PUW = 3'd5, S_UNG = 3'd6;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [2:0]  sleep_i = '0;
  logic        wake_i = 1'b0;
  logic        cfg_en_i = 1'b0;
  logic [15:0] cfg_idle_cycles_i = '0;
  logic        cfg_retentive_i = 1'b0;
  logic        clk_en_o;
  logic [1:0]  pwrgate_no;
  logic [1:0]  pwrgate_ack_ni = 2'b11;
  logic [1:0]  set_retentive_no;
  logic [2:0]  state_o;
  logic        asleep_o;

  int n_cmp = 0;
  int n_err = 0;

  eros_pwr_seq dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sleep_i(sleep_i), .wake_i(wake_i),
    .cfg_en_i(cfg_en_i), .cfg_idle_cycles_i(cfg_idle_cycles_i),
    .cfg_retentive_i(cfg_retentive_i), .clk_en_o(clk_en_o), .pwrgate_no(pwrgate_no),
    .pwrgate_ack_ni(pwrgate_ack_ni), .set_retentive_no(set_retentive_no),
    .state_o(state_o), .asleep_o(asleep_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        rst_n;
    logic [2:0]  sleep;
    logic        wake;
    logic        en;
    logic [15:0] idle;
    logic        ret;
    logic [1:0]  ack;
    logic [2:0]  st;
    logic        ce;
    logic [1:0]  pg;
    logic [1:0]  sr;
    logic        as;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic [2:0] sleep, input logic wake,
                     input logic en, input logic [15:0] idle, input logic ret,
                     input logic [1:0] ack, input logic [2:0] st, input logic ce,
                     input logic [1:0] pg, input logic [1:0] sr, input logic as);
    vec_t v;
    v.rst_n = rst_n; v.sleep = sleep; v.wake = wake; v.en = en; v.idle = idle;
    v.ret = ret; v.ack = ack; v.st = st; v.ce = ce; v.pg = pg; v.sr = sr; v.as = as;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst_n, input logic [2:0] sleep, input logic wake,
                       input logic en, input logic [15:0] idle, input logic ret,
                       input logic [1:0] ack);
    rst_ni = rst_n; sleep_i = sleep; wake_i = wake; cfg_en_i = en;
    cfg_idle_cycles_i = idle; cfg_retentive_i = ret; pwrgate_ack_ni = ack;
  endtask

  task automatic cmp(input string nm, input logic [2:0] got, input logic [2:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
    end
  endtask

  // One clock edge, then check every output 1 ns later.
  task automatic tick_chk(input string nm, input logic [2:0] st, input logic ce,
                          input logic [1:0] pg, input logic [1:0] sr, input logic as);
    @(posedge clk_i);
    #1;
    cmp({nm, ".state"}, state_o, st);
    cmp({nm, ".clk_en"}, {2'b0, clk_en_o}, {2'b0, ce});
    cmp({nm, ".pwrgate_n"}, {1'b0, pwrgate_no}, {1'b0, pg});
    cmp({nm, ".set_ret_n"}, {1'b0, set_retentive_no}, {1'b0, sr});
    cmp({nm, ".asleep"}, {2'b0, asleep_o}, {2'b0, as});
  endtask

  initial begin
    // reset
    add(0, 3'b111, 0, 0, 16'd3, 0, 2'b11, S_ACT, 1, 2'b11, 2'b11, 0);
    // non-retentive power-down, idle=3
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_IDL, 1, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_IDL, 1, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_IDL, 1, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_IDL, 1, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_GAT, 0, 2'b11, 2'b11, 0);
    for (int i = 0; i < 5; i++)
      add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_PDW, 0, 2'b00, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b00, S_SLP, 0, 2'b00, 2'b11, 1);
    add(1, 3'b111, 0, 1, 16'd3, 1, 2'b00, S_SLP, 0, 2'b00, 2'b11, 1);
    // wake, power back up
    add(1, 3'b111, 1, 1, 16'd3, 0, 2'b00, S_PUW, 0, 2'b11, 2'b11, 0);
    for (int i = 0; i < 3; i++)
      add(1, 3'b111, 0, 1, 16'd3, 0, 2'b00, S_PUW, 0, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd3, 0, 2'b11, S_UNG, 0, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 0, 16'd3, 0, 2'b11, S_ACT, 1, 2'b11, 2'b11, 0);
    // retentive sleep, idle=0
    add(1, 3'b111, 0, 1, 16'd0, 1, 2'b11, S_IDL, 1, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd0, 1, 2'b11, S_GAT, 0, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 1, 16'd0, 1, 2'b11, S_SLP, 0, 2'b11, 2'b00, 1);
    add(1, 3'b111, 0, 1, 16'd0, 0, 2'b11, S_SLP, 0, 2'b11, 2'b00, 1);
    add(1, 3'b111, 1, 1, 16'd0, 0, 2'b11, S_UNG, 0, 2'b11, 2'b11, 0);
    add(1, 3'b111, 0, 0, 16'd0, 0, 2'b11, S_ACT, 1, 2'b11, 2'b11, 0);

    @(negedge clk_i);
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst_n, vecs[i].sleep, vecs[i].wake, vecs[i].en, vecs[i].idle,
            vecs[i].ret, vecs[i].ack);
      tick_chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].ce, vecs[i].pg, vecs[i].sr,
               vecs[i].as);
    end

    // Idle abort at count 2 of 10, then re-entry must restart from 0.
    drive(1, 3'b111, 0, 1, 16'd10, 0, 2'b11);
    for (int i = 0; i < 3; i++)
      tick_chk($sformatf("abort_idle%0d", i), S_IDL, 1, 2'b11, 2'b11, 0);
    drive(1, 3'b101, 0, 1, 16'd10, 0, 2'b11);
    tick_chk("abort_act", S_ACT, 1, 2'b11, 2'b11, 0);
    drive(1, 3'b111, 0, 1, 16'd10, 0, 2'b11);
    for (int i = 0; i < 11; i++)
      tick_chk($sformatf("reentry_idle%0d", i), S_IDL, 1, 2'b11, 2'b11, 0);
    tick_chk("reentry_gate", S_GAT, 0, 2'b11, 2'b11, 0);

    // Wake during PD_WAIT is held until the handshake completes.
    tick_chk("pdw_enter", S_PDW, 0, 2'b00, 2'b11, 0);
    drive(1, 3'b111, 1, 1, 16'd10, 0, 2'b11);
    tick_chk("pdw_wake", S_PDW, 0, 2'b00, 2'b11, 0);
    drive(1, 3'b111, 0, 1, 16'd10, 0, 2'b11);
    for (int i = 0; i < 3; i++)
      tick_chk($sformatf("pdw_hold%0d", i), S_PDW, 0, 2'b00, 2'b11, 0);
    drive(1, 3'b111, 0, 1, 16'd10, 0, 2'b00);
    tick_chk("pend_sleep", S_SLP, 0, 2'b00, 2'b11, 1);
    tick_chk("pend_puw", S_PUW, 0, 2'b11, 2'b11, 0);

    // Reset mid power-up handshake.
    drive(0, 3'b111, 0, 1, 16'd10, 0, 2'b00);
    tick_chk("rst_puw", S_ACT, 1, 2'b11, 2'b11, 0);

    // After reset, retentive sleep must not exit on a stale pending wake.
    drive(1, 3'b111, 0, 1, 16'd0, 1, 2'b11);
    tick_chk("post_rst_idle", S_IDL, 1, 2'b11, 2'b11, 0);
    tick_chk("post_rst_gate", S_GAT, 0, 2'b11, 2'b11, 0);
    tick_chk("post_rst_slp0", S_SLP, 0, 2'b11, 2'b00, 1);
    tick_chk("post_rst_slp1", S_SLP, 0, 2'b11, 2'b00, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/eros_pwr_seq.md
EROS_PWR_SEQ -- requirements
Module: eros_pwr_seq

Interface
REQ-001 Parameter NHARTS, 3, number of harts whose sleep status is monitored.
REQ-002 Parameter N_BANKS, 2, number of memory banks under power control.
REQ-003 Parameter CNT_W, 16, idle-counter width.
REQ-004 One clock; reset is synchronous and active-low; ports are clk_i and rst_ni.
REQ-005 clk_i  input  1  free-running, ungated clock.
REQ-006 rst_ni  input  1  synchronous active-low reset.
REQ-007 sleep_i  input  NHARTS  per-hart sleep status from the downstream top wrapper's sleep_o.
REQ-008 wake_i  input  1  wake request (interrupt or debug request), level.
REQ-009 cfg_en_i  input  1  enables automatic power-down.
REQ-010 cfg_idle_cycles_i  input  CNT_W  idle cycles required before clock gating.
REQ-011 cfg_retentive_i  input  1  1 = retention sleep, 0 = full bank power-off.
REQ-012 clk_en_o  output  1  drives the wrapper en_i clock-gate enable.
REQ-013 pwrgate_no  output  N_BANKS  active-low bank power-off request, to wrapper pwrgate_ni.
REQ-014 pwrgate_ack_ni  input  N_BANKS  active-low bank power acknowledge, from wrapper pwrgate_ack_no.
REQ-015 set_retentive_no  output  N_BANKS  active-low retention request, to wrapper set_retentive_ni.
REQ-016 state_o  output  3  current FSM state encoding; asleep_o  output  1  high only in SLEEP.

Function
REQ-017 FSM states and encodings SHALL be ACTIVE=0, IDLE=1, GATE_CLK=2, PD_WAIT=3, SLEEP=4, PU_WAIT=5, UNGATE=6; all outputs are Moore-decoded from registered state.
REQ-018 ACTIVE->IDLE SHALL occur when cfg_en_i=1, all sleep_i bits=1 and wake_i=0; idle counter cleared to 0 on entry.
REQ-019 In IDLE, when wake_i=1, cfg_en_i=0, or any sleep_i bit=0, the FSM SHALL return to ACTIVE (priority over expiry).
REQ-020 Otherwise in IDLE, when counter==cfg_idle_cycles_i, go to GATE_CLK; else counter increments by 1; IDLE lasts cfg_idle_cycles_i+1 cycles (0 -> one cycle).
REQ-021 clk_en_o SHALL be 1 in ACTIVE and IDLE, 0 in GATE_CLK, PD_WAIT, SLEEP, PU_WAIT, UNGATE.
REQ-022 GATE_CLK lasts exactly one cycle and captures cfg_retentive_i into mode_q; next state PD_WAIT if mode_q=0, SLEEP if mode_q=1.
REQ-023 pwrgate_no SHALL be all-0 in PD_WAIT and SLEEP when mode_q=0, all-1 elsewhere.
REQ-024 set_retentive_no SHALL be all-0 in SLEEP when mode_q=1, all-1 elsewhere.
REQ-025 PD_WAIT SHALL advance to SLEEP only when all pwrgate_ack_ni bits are 0; no timeout.
REQ-026 wake_i asserted in GATE_CLK or PD_WAIT SHALL set wake_pend_q; the power-down handshake is never aborted.
REQ-027 SLEEP exits on wake_i or wake_pend_q: to PU_WAIT if mode_q=0, to UNGATE if mode_q=1; wake_pend_q clears on SLEEP exit.
REQ-028 PU_WAIT SHALL advance to UNGATE only when all pwrgate_ack_ni bits are 1.
REQ-029 UNGATE lasts exactly one cycle (clk_en_o still 0, supplies restored) then goes to ACTIVE.
REQ-030 cfg_* changes while not in ACTIVE/IDLE SHALL not affect the current sequence, except cfg_idle_cycles_i compared live in IDLE.

Reset
REQ-031 With rst_ni=0 at a clk_i edge: state=ACTIVE, counter=0, mode_q=0, wake_pend_q=0; clk_en_o=1, pwrgate_no and set_retentive_no all-1, asleep_o=0.
REQ-032 Reset in any state, including PD_WAIT/PU_WAIT mid-handshake, SHALL take effect on the next edge with no drain.

Verification
REQ-033 cfg_en=1, idle=3, ret=0, sleep=3'b111 -> IDLE 4 cycles, GATE_CLK, PD_WAIT pwrgate_no=2'b00; acks 0 after 5 cycles -> SLEEP, asleep_o=1.
REQ-034 From SLEEP (ret=0), wake_i pulse -> PU_WAIT pwrgate_no=2'b11; acks 1 after 4 cycles -> UNGATE 1 cycle -> ACTIVE, clk_en_o=1.
REQ-035 ret=1, idle=0 -> IDLE 1 cycle, GATE_CLK, SLEEP set_retentive_no=2'b00, pwrgate_no=2'b11; wake_i -> UNGATE -> ACTIVE.
REQ-036 In IDLE at count 2 of 10, sleep_i=3'b101 -> ACTIVE next cycle, clk_en_o stays 1; re-entry restarts count at 0.
REQ-037 wake_i in PD_WAIT with acks held 1 -> stays PD_WAIT; acks drop -> SLEEP 1 cycle then PU_WAIT via wake_pend_q.
REQ-038 rst_ni=0 during PU_WAIT -> next cycle ACTIVE, all outputs at reset values.
